// File: rtl/pc_sequencer.sv
// Fetch/decode sequencer for the 8-bit CPU: drives PC control and the instruction-fetch handshake,
// and resolves JMP/JZ/CALL/RET/HALT locally using a small return-address stack.
module pc_sequencer #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] pc_addr,
    output logic       imem_req,
    input  logic       imem_valid,
    input  logic [7:0] imem_rdata,
    input  logic       flag_z,
    output logic       pc_en,
    output logic       pc_chg_en,
    output logic [7:0] pc_chg_addr,
    output logic [7:0] ir,
    output logic       exec_valid,
    output logic       halted,
    output logic       stack_err
);

    localparam int unsigned SpW = $clog2(STACK_DEPTH);
    localparam logic [SpW:0] SpFull = (SpW + 1)'(STACK_DEPTH);
    localparam logic [SpW:0] SpOne  = (SpW + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StFetchOp,
        StExec,
        StHalt
    } state_e;

    state_e       state_q, state_d;
    logic [7:0]   ir_q, ir_d;
    logic [SpW:0] sp_q, sp_d;
    logic         halted_q, halted_d;
    logic         err_q, err_d;
    logic [7:0]   stack_q [STACK_DEPTH];

    logic         push, pop;
    logic         req_c, en_c, chg_c, exec_c;
    logic [7:0]   addr_c;
    logic [3:0]   opcode;
    logic         stack_full, stack_empty;
    logic [SpW-1:0] top_idx;
    logic [7:0]   ret_addr;
    state_e       boundary;

    assign opcode      = ir_q[7:4];
    assign stack_full  = (sp_q == SpFull);
    assign stack_empty = (sp_q == '0);
    assign top_idx     = SpW'(sp_q - SpOne);
    assign ret_addr    = pc_addr + 8'd1;
    assign boundary    = run ? StFetch : StIdle;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        sp_d     = sp_q;
        halted_d = halted_q;
        err_d    = err_q;
        push     = 1'b0;
        pop      = 1'b0;
        req_c    = 1'b0;
        en_c     = 1'b0;
        chg_c    = 1'b0;
        exec_c   = 1'b0;
        addr_c   = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                req_c = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    en_c    = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode <= 4'hB) begin
                    state_d = StExec;
                end else if (opcode != 4'hF) begin
                    state_d = StFetchOp;
                end else if (ir_q[3:0] == 4'h0) begin
                    if (stack_empty) begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else begin
                        en_c    = 1'b1;
                        chg_c   = 1'b1;
                        addr_c  = stack_q[top_idx];
                        pop     = 1'b1;
                        sp_d    = sp_q - SpOne;
                        state_d = boundary;
                    end
                end else if (ir_q[3:0] == 4'hF) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else begin
                    state_d = boundary;
                end
            end
            StFetchOp: begin
                req_c = 1'b1;
                if (imem_valid) begin
                    state_d = boundary;
                    case (opcode)
                        4'hC: begin
                            en_c   = 1'b1;
                            chg_c  = 1'b1;
                            addr_c = imem_rdata;
                        end
                        4'hD: begin
                            // Not taken still advances past the operand byte.
                            en_c   = 1'b1;
                            chg_c  = flag_z;
                            addr_c = flag_z ? imem_rdata : 8'h00;
                        end
                        4'hE: begin
                            if (stack_full) begin
                                err_d    = 1'b1;
                                halted_d = 1'b1;
                                state_d  = StHalt;
                            end else begin
                                push   = 1'b1;
                                sp_d   = sp_q + SpOne;
                                en_c   = 1'b1;
                                chg_c  = 1'b1;
                                addr_c = imem_rdata;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StExec: begin
                exec_c  = 1'b1;
                state_d = boundary;
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ir_q     <= 8'h00;
            sp_q     <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            sp_q     <= sp_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Stack contents need no reset: validity is tracked by sp_q alone.
    always_ff @(posedge clk) begin
        if (rst_n && push) stack_q[sp_q[SpW-1:0]] <= ret_addr;
    end

    assign imem_req    = rst_n & req_c;
    assign pc_en       = rst_n & en_c;
    assign pc_chg_en   = rst_n & chg_c;
    assign pc_chg_addr = (rst_n & chg_c) ? addr_c : 8'h00;
    assign exec_valid  = rst_n & exec_c;
    assign ir          = ir_q;
    assign halted      = halted_q;
    assign stack_err   = err_q;

endmodule
